// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU function codes, condition
// codes and the "no register" ID, plus the condition-evaluation helper.
package y86_pkg;

    localparam int unsigned FIELD_W = 4;

    // Instruction codes
    localparam logic [FIELD_W-1:0] ICODE_HALT   = 4'h0;
    localparam logic [FIELD_W-1:0] ICODE_NOP    = 4'h1;
    localparam logic [FIELD_W-1:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [FIELD_W-1:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [FIELD_W-1:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [FIELD_W-1:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [FIELD_W-1:0] ICODE_OPQ    = 4'h6;
    localparam logic [FIELD_W-1:0] ICODE_JXX    = 4'h7;
    localparam logic [FIELD_W-1:0] ICODE_CALL   = 4'h8;
    localparam logic [FIELD_W-1:0] ICODE_RET    = 4'h9;
    localparam logic [FIELD_W-1:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [FIELD_W-1:0] ICODE_POPQ   = 4'hB;

    // ALU function codes (OPq ifun)
    localparam logic [FIELD_W-1:0] ALU_ADD = 4'h0;
    localparam logic [FIELD_W-1:0] ALU_SUB = 4'h1;
    localparam logic [FIELD_W-1:0] ALU_AND = 4'h2;
    localparam logic [FIELD_W-1:0] ALU_XOR = 4'h3;

    // Condition codes (jXX / cmovXX ifun)
    localparam logic [FIELD_W-1:0] COND_YES = 4'h0;
    localparam logic [FIELD_W-1:0] COND_LE  = 4'h1;
    localparam logic [FIELD_W-1:0] COND_L   = 4'h2;
    localparam logic [FIELD_W-1:0] COND_E   = 4'h3;
    localparam logic [FIELD_W-1:0] COND_NE  = 4'h4;
    localparam logic [FIELD_W-1:0] COND_GE  = 4'h5;
    localparam logic [FIELD_W-1:0] COND_G   = 4'h6;

    localparam logic [FIELD_W-1:0] REG_NONE = 4'hF;

    // Evaluate a condition code against the flags; unknown codes are false.
    function automatic logic cond_eval(input logic [FIELD_W-1:0] fun,
                                       input logic zf, input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (fun)
            COND_YES: cond_eval = 1'b1;
            COND_LE:  cond_eval = lt | zf;
            COND_L:   cond_eval = lt;
            COND_E:   cond_eval = zf;
            COND_NE:  cond_eval = ~zf;
            COND_GE:  cond_eval = ~lt;
            COND_G:   cond_eval = ~lt & ~zf;
            default:  cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU with flag generation.
// Ports: alu_a, alu_b operands; alu_fun function code; val_e_c result;
//        zf_c/sf_c/of_c flags; fun_err_c set for an unknown function code
//        (result forced to zero).
module y86_alu #(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [3:0]        alu_fun,
    output logic [DATA_W-1:0] val_e_c,
    output logic              zf_c,
    output logic              sf_c,
    output logic              of_c,
    output logic              fun_err_c
);
    import y86_pkg::*;

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] neg_a;

    // Subtraction is formed as aluB + (-aluA) so OF uses the sign of -aluA.
    always_comb begin
        neg_a     = DATA_W'(0) - alu_a;
        val_e_c   = '0;
        of_c      = 1'b0;
        fun_err_c = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                val_e_c = alu_a + alu_b;
                of_c    = (alu_a[MSB] == alu_b[MSB]) && (val_e_c[MSB] != alu_a[MSB]);
            end
            ALU_SUB: begin
                val_e_c = alu_b + neg_a;
                of_c    = (neg_a[MSB] == alu_b[MSB]) && (val_e_c[MSB] != neg_a[MSB]);
            end
            ALU_AND: val_e_c = alu_a & alu_b;
            ALU_XOR: val_e_c = alu_a ^ alu_b;
            default: fun_err_c = 1'b1;
        endcase
        zf_c = (val_e_c == '0);
        sf_c = val_e_c[MSB];
    end

endmodule

// File: rtl/execute_pipe.sv
// Y86 execute stage: operand selection, ALU, condition-code register,
// condition evaluation and the E/M pipeline output register.
// Ports: clk, rst_n (async active-low); in_valid/stall/bubble/cc_block
//        control; icode/ifun/valA/valB/valC/dstE/dstM decoded inputs;
//        out_* registered stage outputs; zf/sf/of condition codes;
//        ifun_err registered illegal-ifun flag.
module execute_pipe #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STACK_STEP = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              bubble,
    input  logic              cc_block,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic [DATA_W-1:0] valC,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    output logic              out_valid,
    output logic              out_cnd,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_dstE,
    output logic [3:0]        out_dstM,
    output logic [DATA_W-1:0] out_valE,
    output logic [DATA_W-1:0] out_valA,
    output logic              zf,
    output logic              sf,
    output logic              of,
    output logic              ifun_err
);
    import y86_pkg::*;

    localparam logic [DATA_W-1:0] STEP_POS = DATA_W'(STACK_STEP);
    localparam logic [DATA_W-1:0] STEP_NEG = DATA_W'(0) - STEP_POS;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_fun;
    logic [DATA_W-1:0] alu_val_e;
    logic              alu_zf;
    logic              alu_sf;
    logic              alu_of;
    logic              alu_err;
    logic              is_cond_insn;
    logic              cnd_c;
    logic              ifun_err_c;
    logic [3:0]        dst_e_c;
    logic              cc_we;

    // ALU operand selection by instruction class
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode)
            ICODE_RRMOVQ: alu_a = valA;
            ICODE_IRMOVQ: alu_a = valC;
            ICODE_RMMOVQ, ICODE_MRMOVQ: begin
                alu_a = valC;
                alu_b = valB;
            end
            ICODE_OPQ: begin
                alu_a = valA;
                alu_b = valB;
            end
            ICODE_CALL, ICODE_PUSHQ: begin
                alu_a = STEP_NEG;
                alu_b = valB;
            end
            ICODE_RET, ICODE_POPQ: begin
                alu_a = STEP_POS;
                alu_b = valB;
            end
            default: ;
        endcase
    end

    assign alu_fun = (icode == ICODE_OPQ) ? ifun : ALU_ADD;

    y86_alu #(.DATA_W(DATA_W)) u_alu (
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .val_e_c   (alu_val_e),
        .zf_c      (alu_zf),
        .sf_c      (alu_sf),
        .of_c      (alu_of),
        .fun_err_c (alu_err)
    );

    // Condition result uses the CC value held before this instruction
    assign is_cond_insn = (icode == ICODE_RRMOVQ) || (icode == ICODE_JXX);
    assign cnd_c        = is_cond_insn && cond_eval(ifun, zf, sf, of);
    assign ifun_err_c   = ((icode == ICODE_OPQ) && alu_err)
                        || (is_cond_insn && (ifun > COND_G));
    // A cmov that is not taken writes no register
    assign dst_e_c      = ((icode == ICODE_RRMOVQ) && !cnd_c) ? REG_NONE : dstE;

    assign cc_we = (icode == ICODE_OPQ) && in_valid && !stall && !bubble
                 && !cc_block && !alu_err;

    // Condition-code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (cc_we) begin
            zf <= alu_zf;
            sf <= alu_sf;
            of <= alu_of;
        end
    end

    // E/M output register: stall holds, bubble or empty slot loads a nop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_cnd   <= 1'b0;
            out_icode <= ICODE_NOP;
            out_dstE  <= REG_NONE;
            out_dstM  <= REG_NONE;
            out_valE  <= '0;
            out_valA  <= '0;
            ifun_err  <= 1'b0;
        end else if (!stall) begin
            if (bubble || !in_valid) begin
                out_valid <= 1'b0;
                out_cnd   <= 1'b0;
                out_icode <= ICODE_NOP;
                out_dstE  <= REG_NONE;
                out_dstM  <= REG_NONE;
                out_valE  <= '0;
                out_valA  <= '0;
                ifun_err  <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                out_cnd   <= cnd_c;
                out_icode <= icode;
                out_dstE  <= dst_e_c;
                out_dstM  <= dstM;
                out_valE  <= alu_val_e;
                out_valA  <= valA;
                ifun_err  <= ifun_err_c;
            end
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: a 64-bit and a 32-bit instance share the
// stimulus; a behavioural model predicts both every cycle, and literal
// expectations pin key results.
module tb_execute_pipe;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] vala;
        logic        cnd;
        logic        err;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, stall, bubble, cc_block;
    logic [3:0]  icode, ifun, dst_e, dst_m;
    logic [63:0] va, vb, vc;

    logic        o64_valid, o64_cnd, z64, s64, f64, e64;
    logic [3:0]  o64_icode, o64_dste, o64_dstm;
    logic [63:0] o64_vale, o64_vala;
    logic        o32_valid, o32_cnd, z32, s32, f32, e32;
    logic [3:0]  o32_icode, o32_dste, o32_dstm;
    logic [31:0] o32_vale, o32_vala;

    out_t m_out [2];
    logic m_zf [2];
    logic m_sf [2];
    logic m_of [2];

    int total;
    int bad;
    bit chk_en;

    execute_pipe #(.DATA_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .bubble(bubble), .cc_block(cc_block), .icode(icode), .ifun(ifun),
        .valA(va), .valB(vb), .valC(vc), .dstE(dst_e), .dstM(dst_m),
        .out_valid(o64_valid), .out_cnd(o64_cnd), .out_icode(o64_icode),
        .out_dstE(o64_dste), .out_dstM(o64_dstm), .out_valE(o64_vale),
        .out_valA(o64_vala), .zf(z64), .sf(s64), .of(f64), .ifun_err(e64)
    );

    execute_pipe #(.DATA_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .bubble(bubble), .cc_block(cc_block), .icode(icode), .ifun(ifun),
        .valA(va[31:0]), .valB(vb[31:0]), .valC(vc[31:0]), .dstE(dst_e), .dstM(dst_m),
        .out_valid(o32_valid), .out_cnd(o32_cnd), .out_icode(o32_icode),
        .out_dstE(o32_dste), .out_dstM(o32_dstm), .out_valE(o32_vale),
        .out_valA(o32_vala), .zf(z32), .sf(s32), .of(f32), .ifun_err(e32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic sgn(input logic [63:0] x, input int w);
        return x[w-1];
    endfunction

    task automatic model_nop(input int k);
        m_out[k] = '{valid: 1'b0, icode: 4'h1, dste: 4'hF, dstm: 4'hF,
                     vale: 64'd0, vala: 64'd0, cnd: 1'b0, err: 1'b0};
    endtask

    // One clock edge of the architectural execute stage for width index k
    task automatic model_step(input int k);
        int          w;
        int          op;
        logic [63:0] m, a, b, r, na, stp;
        logic        c, bad_op, is_c, lt;
        w   = (k == 0) ? 64 : 32;
        m   = msk(w);
        stp = 64'(w / 8);
        if (stall) return;
        if (bubble || !in_valid) begin
            model_nop(k);
            return;
        end
        a = 64'd0;
        b = 64'd0;
        case (icode)
            4'h2:       a = va & m;
            4'h3:       a = vc & m;
            4'h4, 4'h5: begin a = vc & m; b = vb & m; end
            4'h6:       begin a = va & m; b = vb & m; end
            4'h8, 4'hA: begin a = (64'd0 - stp) & m; b = vb & m; end
            4'h9, 4'hB: begin a = stp; b = vb & m; end
            default: ;
        endcase
        bad_op = (icode == 4'h6) && (ifun > 4'h3);
        op     = (icode == 4'h6) ? int'(ifun) : 0;
        case (op)
            0:       r = a + b;
            1:       r = b - a;
            2:       r = a & b;
            3:       r = a ^ b;
            default: r = 64'd0;
        endcase
        r    = r & m;
        is_c = (icode == 4'h2) || (icode == 4'h7);
        lt   = m_sf[k] ^ m_of[k];
        c    = 1'b0;
        if (is_c) begin
            case (ifun)
                4'h0: c = 1'b1;
                4'h1: c = lt | m_zf[k];
                4'h2: c = lt;
                4'h3: c = m_zf[k];
                4'h4: c = !m_zf[k];
                4'h5: c = !lt;
                4'h6: c = !lt && !m_zf[k];
                default: c = 1'b0;
            endcase
        end
        m_out[k].valid = 1'b1;
        m_out[k].icode = icode;
        m_out[k].dste  = ((icode == 4'h2) && !c) ? 4'hF : dst_e;
        m_out[k].dstm  = dst_m;
        m_out[k].vale  = r;
        m_out[k].vala  = va & m;
        m_out[k].cnd   = c;
        m_out[k].err   = bad_op || (is_c && (ifun > 4'h6));
        if ((icode == 4'h6) && !cc_block && !bad_op) begin
            na      = (64'd0 - a) & m;
            m_zf[k] = (r == 64'd0);
            m_sf[k] = sgn(r, w);
            if (op == 0)
                m_of[k] = (sgn(a, w) == sgn(b, w)) && (sgn(r, w) != sgn(a, w));
            else if (op == 1)
                m_of[k] = (sgn(na, w) == sgn(b, w)) && (sgn(r, w) != sgn(na, w));
            else
                m_of[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                model_nop(k);
                m_zf[k] = 1'b1;
                m_sf[k] = 1'b0;
                m_of[k] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            out_t a;
            a = '{valid: o64_valid, icode: o64_icode, dste: o64_dste, dstm: o64_dstm,
                  vale: o64_vale, vala: o64_vala, cnd: o64_cnd, err: e64};
            chk("model64.out", 160'(a), 160'(m_out[0]));
            chk("model64.cc", 160'({z64, s64, f64}), 160'({m_zf[0], m_sf[0], m_of[0]}));
            a = '{valid: o32_valid, icode: o32_icode, dste: o32_dste, dstm: o32_dstm,
                  vale: {32'd0, o32_vale}, vala: {32'd0, o32_vala}, cnd: o32_cnd, err: e32};
            chk("model32.out", 160'(a), 160'(m_out[1]));
            chk("model32.cc", 160'({z32, s32, f32}), 160'({m_zf[1], m_sf[1], m_of[1]}));
        end
    end

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [3:0] de);
        icode = ic;
        ifun  = fn;
        va    = a;
        vb    = b;
        vc    = c;
        dst_e = de;
        dst_m = 4'h7;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        stall    = 1'b0;
        bubble   = 1'b0;
        cc_block = 1'b0;
    endtask

    logic [63:0] cva [3];
    logic [63:0] cvb [3];

    initial begin
        total = 0; bad = 0; chk_en = 0;
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; bubble = 1'b0; cc_block = 1'b0;
        icode = 4'h0; ifun = 4'h0; va = 0; vb = 0; vc = 0; dst_e = 4'hF; dst_m = 4'hF;
        cva = '{64'd5, 64'd5, 64'd3};
        cvb = '{64'd5, 64'd3, 64'd5};

        #12;
        chk("reset.icode", 160'(o64_icode), 160'(4'h1));
        chk("reset.dstE", 160'(o64_dste), 160'(4'hF));
        chk("reset.valid", 160'(o64_valid), 160'(1'b0));
        chk("reset.cc", 160'({z64, s64, f64}), 160'(3'b100));
        chk("reset32.cc", 160'({z32, s32, f32}), 160'(3'b100));
        #10;
        rst_n = 1'b1;
        chk_en = 1;
        in_valid = 1'b1;

        drive(4'h6, 4'h0, 64'd4, 64'd100, 0, 4'h2);
        chk("addq.valE", 160'(o64_vale), 160'(64'd104));
        chk("addq.cc", 160'({z64, s64, f64}), 160'(3'b000));

        drive(4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h2);
        chk("subq.valE", 160'(o64_vale), 160'(64'd0));
        chk("subq.zf", 160'(z64), 160'(1'b1));

        drive(4'h2, 4'h3, 64'h55, 0, 0, 4'h3);
        chk("cmove.cnd", 160'(o64_cnd), 160'(1'b1));
        chk("cmove.dstE", 160'(o64_dste), 160'(4'h3));

        drive(4'h2, 4'h4, 64'h55, 0, 0, 4'h3);
        chk("cmovne.dstE", 160'(o64_dste), 160'(4'hF));

        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 4'h4);
        chk("ovf.valE", 160'(o64_vale), 160'(64'h8000_0000_0000_0000));
        chk("ovf.cc", 160'({z64, s64, f64}), 160'(3'b011));

        drive(4'h7, 4'h2, 0, 0, 64'h400, 4'hF);
        chk("jl.cnd", 160'(o64_cnd), 160'(1'b0));

        drive(4'hA, 4'h0, 64'h33, 64'h100, 0, 4'h4);
        chk("pushq.valE", 160'(o64_vale), 160'(64'hF8));
        chk("pushq32.valE", 160'(o32_vale), 160'(32'hFC));
        chk("pushq.cc", 160'({z64, s64, f64}), 160'(3'b011));

        stall = 1'b1;
        drive(4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h5);
        chk("stall.icode", 160'(o64_icode), 160'(4'hA));
        chk("stall.valE", 160'(o64_vale), 160'(64'hF8));
        chk("stall.cc", 160'({z64, s64, f64}), 160'(3'b011));

        stall = 1'b1; bubble = 1'b1;
        drive(4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h5);
        chk("stallbub.icode", 160'(o64_icode), 160'(4'hA));

        bubble = 1'b1;
        drive(4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h5);
        chk("bubble.nop", 160'({o64_icode, o64_dste, o64_valid}), 160'({4'h1, 4'hF, 1'b0}));

        cc_block = 1'b1;
        drive(4'h6, 4'h0, 64'd1, 64'd2, 0, 4'h5);
        chk("ccblock.valE", 160'(o64_vale), 160'(64'd3));
        chk("ccblock.cc", 160'({z64, s64, f64}), 160'(3'b011));

        in_valid = 1'b0;
        drive(4'h6, 4'h0, 64'd1, 64'd2, 0, 4'h5);
        chk("invalid.valid", 160'(o64_valid), 160'(1'b0));

        drive(4'h6, 4'h5, 64'd1, 64'd2, 0, 4'h5);
        chk("badop", 160'({o64_vale, e64, z64, s64, f64}), 160'({64'd0, 1'b1, 3'b011}));

        drive(4'h2, 4'h7, 64'd1, 0, 0, 4'h5);
        chk("badcond", 160'({o64_cnd, e64, o64_dste}), 160'({1'b0, 1'b1, 4'hF}));

        drive(4'h5, 4'h0, 0, 64'h10, 64'd8, 4'h6);
        chk("mrmovq.valE", 160'(o64_vale), 160'(64'h18));
        drive(4'hB, 4'h0, 0, 64'h100, 0, 4'h4);
        chk("popq.valE", 160'(o64_vale), 160'(64'h108));
        drive(4'h3, 4'h0, 0, 0, 64'hDEAD, 4'h6);
        drive(4'h8, 4'h0, 0, 64'h200, 64'h40, 4'h4);
        drive(4'h9, 4'h0, 0, 64'h200, 0, 4'h4);
        drive(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 0, 4'h1);
        chk("andq.valE", 160'(o64_vale), 160'(64'hF000));
        drive(4'h6, 4'h3, 64'hF0F0, 64'hFF00, 0, 4'h1);
        chk("xorq.valE", 160'(o64_vale), 160'(64'h0FF0));
        drive(4'h0, 4'h0, 64'd9, 64'd9, 64'd9, 4'h1);
        drive(4'h4, 4'h0, 64'd1, 64'h20, 64'h8, 4'hF);

        for (int i = 0; i < 3; i++) begin
            drive(4'h6, 4'h1, cva[i], cvb[i], 0, 4'h2);
            for (int f = 0; f < 7; f++) begin
                drive(4'h7, 4'(f), 0, 0, 64'h80, 4'hF);
                if (i == 1 && f == 1) chk("jle.neg", 160'(o64_cnd), 160'(1'b1));
                if (i == 1 && f == 6) chk("jg.neg", 160'(o64_cnd), 160'(1'b0));
            end
            drive(4'h2, 4'h5, 64'h11, 0, 0, 4'h3);
        end

        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 4'h2);
        chk("subovf.of", 160'(f64), 160'(1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstpulse.out", 160'({o64_valid, o64_icode, o64_dste, o64_vale}),
            160'({1'b0, 4'h1, 4'hF, 64'd0}));
        chk("rstpulse.cc", 160'({z64, f64}), 160'(2'b10));
        #1;
        rst_n = 1'b1;
        drive(4'h6, 4'h0, 64'd2, 64'd3, 0, 4'h2);
        chk("postrst.valE", 160'({o64_valid, o64_vale}), 160'({1'b1, 64'd5}));

        in_valid = 1'b0;
        drive(4'h1, 4'h0, 0, 0, 0, 4'hF);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
